rvfi_trace_packer: RTL and testbench



---
 rtl/rvfi_trace_pkg.sv | 39 +++
 rtl/rvfi_rec_fifo.sv | 60 ++++++
 rtl/rvfi_trace_packer.sv | 135 +++++++++++++
 tb/tb_rvfi_trace_packer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rvfi_trace_pkg.sv
// Shared types and constants for the RVFI retirement trace packer.
// A record is one retired instruction; rec_word() picks one of its stream words.
package rvfi_trace_pkg;

  localparam logic [7:0] TRACE_SYNC = 8'hA5;
  localparam int         REC_WORDS  = 7;
  localparam logic [2:0] LAST_IDX   = 3'(REC_WORDS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  typedef struct packed {
    logic [7:0]  seq;
    logic [4:0]  rd_addr;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
  } rvfi_rec_t;

  function automatic logic [31:0] rec_word(input rvfi_rec_t rec, input logic [2:0] idx);
    logic [31:0] w;
    case (idx)
      3'd0:    w = {TRACE_SYNC, rec.seq, 11'b0, rec.rd_addr};
      3'd1:    w = rec.pc;
      3'd2:    w = rec.insn;
      3'd3:    w = rec.rd_wdata;
      3'd4:    w = rec.mem_addr;
      3'd5:    w = rec.mem_wdata;
      default: w = rec.mem_rdata;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/rvfi_rec_fifo.sv
// Synchronous record FIFO. A push is accepted while full when the head pops in the same cycle.
// head_next exposes the second entry so the serialiser can chain records without a bubble.
module rvfi_rec_fifo
  import rvfi_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  rvfi_rec_t push_rec,
  input  logic      pop,
  output rvfi_rec_t head,
  output rvfi_rec_t head_next,
  output logic      full,
  output logic      empty,
  output logic      multi
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  rvfi_rec_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign multi     = (count >= (AW + 1)'(2));
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && (!full || pop_ok);
  assign head      = mem[rd_ptr];
  assign head_next = mem[rd_ptr + AW'(1)];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_rec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rvfi_trace_packer.sv
// Captures RVFI retirements into records and serialises each as seven 32-bit stream words.
// Records that find the FIFO full are dropped and counted; seq advances either way.
module rvfi_trace_packer
  import rvfi_trace_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DROP_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trace_en,
  input  logic              rvfi_valid,
  input  logic [31:0]       rvfi_pc_rdata,
  input  logic [31:0]       rvfi_insn,
  input  logic [4:0]        rvfi_rd_addr,
  input  logic [31:0]       rvfi_rd_wdata,
  input  logic [31:0]       rvfi_mem_addr,
  input  logic [31:0]       rvfi_mem_wdata,
  input  logic [31:0]       rvfi_mem_rdata,
  output logic [31:0]       m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count
);

  state_t    state;
  logic [2:0] idx;
  logic [7:0] seq;
  rvfi_rec_t in_rec;
  rvfi_rec_t head;
  rvfi_rec_t head_next;
  logic      fifo_full;
  logic      fifo_empty;
  logic      fifo_multi;
  logic      capture;
  logic      xfer;
  logic      last_xfer;
  logic      push;
  logic      drop;

  assign in_rec = '{
    seq:       seq,
    rd_addr:   rvfi_rd_addr,
    pc:        rvfi_pc_rdata,
    insn:      rvfi_insn,
    rd_wdata:  rvfi_rd_wdata,
    mem_addr:  rvfi_mem_addr,
    mem_wdata: rvfi_mem_wdata,
    mem_rdata: rvfi_mem_rdata
  };

  assign capture   = rvfi_valid && trace_en;
  assign xfer      = (state == SEND) && m_valid && m_ready;
  assign last_xfer = xfer && (idx == LAST_IDX);
  assign push      = capture && (!fifo_full || last_xfer);
  assign drop      = capture && !push;

  rvfi_rec_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_rec  (in_rec),
    .pop       (last_xfer),
    .head      (head),
    .head_next (head_next),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .multi     (fifo_multi)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      seq        <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (capture) seq <= seq + 8'd1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != {DROP_W{1'b1}}) drop_count <= drop_count + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state   <= SEND;
            idx     <= '0;
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            m_data  <= rec_word(head, 3'd0);
          end
        end
        SEND: begin
          if (last_xfer) begin
            // Next record is either already queued behind the head or arriving right now.
            idx    <= '0;
            m_last <= 1'b0;
            if (fifo_multi) begin
              m_data <= rec_word(head_next, 3'd0);
            end else if (push) begin
              m_data <= rec_word(in_rec, 3'd0);
            end else begin
              state   <= IDLE;
              m_valid <= 1'b0;
              m_data  <= '0;
            end
          end else if (xfer) begin
            idx    <= idx + 3'd1;
            m_last <= ((idx + 3'd1) == LAST_IDX);
            m_data <= rec_word(head, idx + 3'd1);
          end
        end
        default: begin
          state   <= IDLE;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rvfi_trace_packer.sv
// Directed bench for rvfi_trace_packer: latency, backpressure, overflow, full+pop, seq wrap, reset.
module tb_rvfi_trace_packer;

  logic        clk;
  logic        reset;
  logic        trace_en;
  logic        rvfi_valid;
  logic [31:0] rvfi_pc_rdata;
  logic [31:0] rvfi_insn;
  logic [4:0]  rvfi_rd_addr;
  logic [31:0] rvfi_rd_wdata;
  logic [31:0] rvfi_mem_addr;
  logic [31:0] rvfi_mem_wdata;
  logic [31:0] rvfi_mem_rdata;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  logic        overflow;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] wq[$];
  logic        lq[$];

  rvfi_trace_packer #(
    .FIFO_DEPTH (8),
    .DROP_W     (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .trace_en       (trace_en),
    .rvfi_valid     (rvfi_valid),
    .rvfi_pc_rdata  (rvfi_pc_rdata),
    .rvfi_insn      (rvfi_insn),
    .rvfi_rd_addr   (rvfi_rd_addr),
    .rvfi_rd_wdata  (rvfi_rd_wdata),
    .rvfi_mem_addr  (rvfi_mem_addr),
    .rvfi_mem_wdata (rvfi_mem_wdata),
    .rvfi_mem_rdata (rvfi_mem_rdata),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_last         (m_last),
    .m_ready        (m_ready),
    .overflow       (overflow),
    .drop_count     (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are stable around the negedge, so this sees exactly what the next edge will transfer.
  always @(negedge clk) begin
    if (!reset && m_valid && m_ready) begin
      wq.push_back(m_data);
      lq.push_back(m_last);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] insn, input logic [4:0] rd,
                        input logic [31:0] wd, input logic [31:0] ma, input logic [31:0] mw,
                        input logic [31:0] mr);
    rvfi_pc_rdata  = pc;
    rvfi_insn      = insn;
    rvfi_rd_addr   = rd;
    rvfi_rd_wdata  = wd;
    rvfi_mem_addr  = ma;
    rvfi_mem_wdata = mw;
    rvfi_mem_rdata = mr;
    rvfi_valid     = 1'b1;
    tick();
    rvfi_valid     = 1'b0;
  endtask

  task automatic wait_words(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && wq.size() < n; i++) tick();
    chk(tag, wq.size(), n);
  endtask

  logic [31:0] exp_w [7];
  logic [31:0] pd;
  logic        pv, pr, pl;

  initial begin
    reset = 1'b1; trace_en = 1'b1; rvfi_valid = 1'b0; m_ready = 1'b1;
    rvfi_pc_rdata = '0; rvfi_insn = '0; rvfi_rd_addr = '0; rvfi_rd_wdata = '0;
    rvfi_mem_addr = '0; rvfi_mem_wdata = '0; rvfi_mem_rdata = '0;
    do_reset();

    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_count, 0);

    // Single retire with one-cycle latency to W0
    wq.delete(); lq.delete();
    retire(32'h10, 32'h0010_0093, 5'd1, 32'd1, 0, 0, 0);
    chk("sgl_valid_n", m_valid, 0);
    tick();
    chk("sgl_valid_n1", m_valid, 1);
    chk("sgl_w0_n1", m_data, 32'hA500_0001);
    chk("sgl_last_n1", m_last, 0);
    wait_words("sgl_cnt", 7, 30);
    exp_w = '{32'hA500_0001, 32'h10, 32'h0010_0093, 32'd1, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 7; i++) begin
      chk("sgl_word", wq[i], exp_w[i]);
      chk("sgl_mlast", lq[i], (i == 6));
    end

    // Backpressure with m_ready toggling
    wq.delete(); lq.delete();
    m_ready = 1'b0;
    retire(32'h100, 32'hDEAD_BEEF, 5'd5, 32'h1234, 32'h2000, 32'hAA55, 32'h77);
    for (int c = 0; c < 40 && wq.size() < 7; c++) begin
      m_ready = c[0];
      pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
      tick();
      if (pv && !pr) begin
        chk("bp_hold_valid", m_valid, 1);
        chk("bp_hold_data", m_data, pd);
        chk("bp_hold_last", m_last, pl);
      end
    end
    m_ready = 1'b1;
    repeat (5) tick();
    chk("bp_cnt", wq.size(), 7);
    exp_w = '{32'hA501_0005, 32'h100, 32'hDEAD_BEEF, 32'h1234, 32'h2000, 32'hAA55, 32'h77};
    for (int i = 0; i < 7; i++) begin
      chk("bp_word", wq[i], exp_w[i]);
      chk("bp_mlast", lq[i], (i == 6));
    end

    // Overflow, then a retire landing on the final pop of a full FIFO
    do_reset();
    wq.delete(); lq.delete();
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) retire(32'h1000 + i, i, 5'd3, i, i, i, i);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", drop_count, 2);
    chk("ovf_head", m_data, 32'hA500_0003);
    m_ready = 1'b1;
    repeat (6) tick();
    chk("fp_last_ready", m_last, 1);
    retire(32'hABC, 32'h13, 5'd7, 0, 0, 0, 0);
    chk("fp_drop", drop_count, 2);
    wait_words("fp_cnt", 63, 200);
    for (int k = 0; k < 8; k++) begin
      chk("ovf_hdr", wq[7*k], 32'hA500_0003 | (k << 16));
      chk("ovf_pc", wq[7*k+1], 32'h1000 + k);
    end
    chk("fp_hdr", wq[56], 32'hA50A_0007);
    chk("fp_pc", wq[57], 32'hABC);
    chk("fp_drop_end", drop_count, 2);

    // Sequence wrap
    do_reset();
    wq.delete(); lq.delete();
    for (int n = 0; n < 256; n++) begin
      retire(n, 0, 5'd0, 0, 0, 0, 0);
      repeat (9) tick();
    end
    wait_words("wrap_cnt", 256 * 7, 100);
    chk("wrap_hdr255", wq[255*7], 32'hA5FF_0000);
    chk("wrap_drop", drop_count, 0);
    wq.delete(); lq.delete();
    retire(32'h5A5A, 0, 5'd0, 0, 0, 0, 0);
    wait_words("wrap_cnt2", 7, 30);
    chk("wrap_hdr256", wq[0], 32'hA500_0000);
    chk("wrap_pc", wq[1], 32'h5A5A);

    // Reset in the middle of a record
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) retire(i, 0, 5'd2, 0, 0, 0, 0);
    chk("mr_drop_pre", drop_count, 2);
    wq.delete(); lq.delete();
    m_ready = 1'b1;
    wait_words("mr_cnt", 4, 30);
    reset = 1'b1;
    tick();
    chk("mr_valid", m_valid, 0);
    chk("mr_drop", drop_count, 0);
    chk("mr_ovf", overflow, 0);
    reset = 1'b0;
    wq.delete(); lq.delete();
    tick();
    chk("mr_idle", m_valid, 0);
    retire(32'h44, 0, 5'd9, 0, 0, 0, 0);
    wait_words("mr_cnt2", 7, 30);
    chk("mr_hdr", wq[0], 32'hA500_0009);
    chk("mr_pc", wq[1], 32'h44);

    // Capture disabled
    wq.delete(); lq.delete();
    trace_en = 1'b0;
    retire(32'h99, 0, 5'd1, 0, 0, 0, 0);
    repeat (10) tick();
    chk("en_valid", m_valid, 0);
    chk("en_cnt", wq.size(), 0);
    trace_en = 1'b1;
    retire(32'h98, 0, 5'd1, 0, 0, 0, 0);
    wait_words("en_cnt2", 7, 30);
    chk("en_hdr", wq[0], 32'hA501_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
